// File: rtl/rsa_sched_pkg.sv
// Shared types and defaults for the RSA job scheduler.
package rsa_sched_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int TIMEOUT_DEF = 1023;
  localparam int CNT_W       = 16;
  localparam int NUM_REQ     = 2;
  localparam int NUM_OPS     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    STAT_OK      = 2'd0,
    STAT_TIMEOUT = 2'd1,
    STAT_ABORTED = 2'd2
  } status_e;

endpackage

// File: rtl/rsa_job_scheduler_if.sv
// Job-side and RSA-unit-side signals of the scheduler; slave = scheduler, master = host/RSA unit.
interface rsa_job_scheduler_if
  import rsa_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic [NUM_REQ-1:0] req;
  logic [WIDTH-1:0]   op_p0, op_e0, op_m0, op_const0;
  logic [WIDTH-1:0]   op_p1, op_e1, op_m1, op_const1;
  logic               abort;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] done;
  logic [1:0]         status;
  logic [WIDTH-1:0]   result;
  logic               busy;
  logic [WIDTH-1:0]   rsa_p, rsa_e, rsa_m, rsa_const;
  logic               en_rsa;
  logic               clear_rsa;
  logic               eoc_rsa;
  logic [WIDTH-1:0]   c_rsa;

  modport slave (
    input  req, op_p0, op_e0, op_m0, op_const0, op_p1, op_e1, op_m1, op_const1,
    input  abort, eoc_rsa, c_rsa,
    output gnt, done, status, result, busy,
    output rsa_p, rsa_e, rsa_m, rsa_const, en_rsa, clear_rsa
  );

  modport master (
    output req, op_p0, op_e0, op_m0, op_const0, op_p1, op_e1, op_m1, op_const1,
    output abort, eoc_rsa, c_rsa,
    input  gnt, done, status, result, busy,
    input  rsa_p, rsa_e, rsa_m, rsa_const, en_rsa, clear_rsa
  );

endinterface

// File: rtl/rsa_sched_rr_arb.sv
// Two-requester round-robin arbiter: the requester not served last wins a tie.
module rsa_sched_rr_arb (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || last)) grant = 2'b01;
    else if (req[1])                 grant = 2'b10;
  end

endmodule

// File: rtl/rsa_job_scheduler.sv
// Grants RSA jobs to two requesters round-robin and sequences the RSA unit
// through clear, run (with timeout/abort) and completion.
module rsa_job_scheduler
  import rsa_sched_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rstb,
  input  logic ena,
  rsa_job_scheduler_if.slave bus
);

  localparam logic [CNT_W:0] TMO = (CNT_W+1)'(TIMEOUT);

  state_e                                 state, state_nx;
  logic [CNT_W-1:0]                       cnt, cnt_nx;
  logic [CNT_W:0]                         cnt_inc;
  logic                                   last, last_nx;
  logic [NUM_REQ-1:0]                     owner, owner_nx;
  logic [NUM_REQ-1:0]                     grant, gnt, done;
  status_e                                status, status_nx;
  logic [WIDTH-1:0]                       result, result_nx;
  logic [NUM_OPS-1:0][WIDTH-1:0]          opl, opl_nx;
  logic [NUM_REQ-1:0][NUM_OPS-1:0][WIDTH-1:0] ops;
  logic                                   en_rsa, clear_rsa;

  // operand slot order: [0]=P, [1]=E, [2]=M, [3]=CONST
  assign ops[0] = {bus.op_const0, bus.op_m0, bus.op_e0, bus.op_p0};
  assign ops[1] = {bus.op_const1, bus.op_m1, bus.op_e1, bus.op_p1};

  rsa_sched_rr_arb u_arb (
    .req   (bus.req),
    .last  (last),
    .grant (grant)
  );

  // value the counter will hold once the current RUN cycle completes
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    last_nx   = last;
    owner_nx  = owner;
    status_nx = status;
    result_nx = result;
    opl_nx    = opl;
    gnt       = '0;
    done      = '0;
    en_rsa    = 1'b0;
    clear_rsa = 1'b0;
    // gnt is combinational in IDLE, so it is also gated while reset is held
    if (ena && rstb) begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            gnt      = grant;
            owner_nx = grant;
            opl_nx   = grant[1] ? ops[1] : ops[0];
            state_nx = ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          clear_rsa = 1'b1;
          cnt_nx    = '0;
          if (bus.abort) begin
            status_nx = STAT_ABORTED;
            state_nx  = ST_DONE;
          end else begin
            state_nx  = ST_RUN;
          end
        end
        ST_RUN: begin
          en_rsa = 1'b1;
          cnt_nx = cnt_inc[CNT_W-1:0];
          if (bus.abort) begin
            status_nx = STAT_ABORTED;
            state_nx  = ST_DONE;
          end else if (bus.eoc_rsa) begin
            result_nx = bus.c_rsa;
            status_nx = STAT_OK;
            state_nx  = ST_DONE;
          end else if (cnt_inc == TMO) begin
            status_nx = STAT_TIMEOUT;
            state_nx  = ST_DONE;
          end
        end
        ST_DONE: begin
          clear_rsa = 1'b1;
          done      = owner;
          last_nx   = owner[1];
          state_nx  = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      last   <= 1'b1;
      owner  <= '0;
      status <= STAT_OK;
      result <= '0;
      opl    <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      last   <= last_nx;
      owner  <= owner_nx;
      status <= status_nx;
      result <= result_nx;
      opl    <= opl_nx;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.done      = done;
  assign bus.status    = status;
  assign bus.result    = result;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.rsa_p     = opl[0];
  assign bus.rsa_e     = opl[1];
  assign bus.rsa_m     = opl[2];
  assign bus.rsa_const = opl[3];
  assign bus.en_rsa    = en_rsa;
  assign bus.clear_rsa = clear_rsa;

endmodule

// File: tb/tb_rsa_job_scheduler.sv
// Randomized job stream against a transaction-level model of the scheduler,
// plus directed reset, round-robin, timeout, abort, freeze and mid-job reset cases.
module tb_rsa_job_scheduler;
  import rsa_sched_pkg::*;

  localparam int W   = 8;
  localparam int TMO = 24;

  logic clk  = 1'b0;
  logic rstb = 1'b1;
  logic ena  = 1'b0;
  always #5 clk = ~clk;

  rsa_job_scheduler_if #(.WIDTH(W)) bus();

  rsa_job_scheduler #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rstb (rstb),
    .ena  (ena),
    .bus  (bus)
  );

  // RSA unit stub: eoc rises in the stub_lat-th enabled cycle after a clear; 0 = never
  int           scnt;
  int           stub_lat;
  logic [W-1:0] stub_c;
  always @(posedge clk or negedge rstb) begin
    if (!rstb)              scnt <= 0;
    else if (bus.clear_rsa) scnt <= 0;
    else if (bus.en_rsa)    scnt <= scnt + 1;
  end
  assign bus.eoc_rsa = (stub_lat != 0) && (scnt >= stub_lat - 1);
  assign bus.c_rsa   = stub_c;

  int           n_chk = 0;
  int           n_pass = 0;
  logic [W-1:0] opv [2][4];
  logic         last_m;
  logic [W-1:0] res_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops();
    bus.op_p0 = opv[0][0]; bus.op_e0 = opv[0][1]; bus.op_m0 = opv[0][2]; bus.op_const0 = opv[0][3];
    bus.op_p1 = opv[1][0]; bus.op_e1 = opv[1][1]; bus.op_m1 = opv[1][2]; bus.op_const1 = opv[1][3];
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 4; j++) opv[i][j] = W'($urandom);
    drive_ops();
  endtask

  // One job: ab_k = RUN cycle of abort (0 = in CLEAR, -1 = none);
  // freeze ena for fz_n cycles starting at RUN cycle fz_s.
  task automatic run_job(input logic [1:0] rq, input int lat, input int ab_k,
                         input int fz_s, input int fz_n, input logic [W-1:0] cv);
    int           win, n, gap, t;
    logic [1:0]   st;
    logic         seen;
    logic [W-1:0] wop [4];
    win = (rq == 2'b11) ? (last_m ? 0 : 1) : (rq[0] ? 0 : 1);
    if (lat == 0 || lat > TMO) begin n = TMO; st = STAT_TIMEOUT; end
    else                       begin n = lat; st = STAT_OK;      end
    if (ab_k >= 0 && ab_k <= n) begin n = ab_k; st = STAT_ABORTED; end
    gap = 2 + n + fz_n;
    for (int i = 0; i < 4; i++) wop[i] = opv[win][i];

    tick();
    stub_lat = lat; stub_c = cv; bus.req = rq; bus.abort = 1'b0;
    #1;
    chk("idle_busy", bus.busy, 0);
    chk("gnt", bus.gnt, 32'(1) << win);

    tick();
    if (ab_k == 0) bus.abort = 1'b1;
    #1;
    chk("rsa_p", bus.rsa_p, wop[0]);
    chk("rsa_e", bus.rsa_e, wop[1]);
    chk("rsa_m", bus.rsa_m, wop[2]);
    chk("rsa_const", bus.rsa_const, wop[3]);
    chk("clr_in_clear", bus.clear_rsa, 1);
    chk("en_in_clear", bus.en_rsa, 0);
    chk("gnt_pulse", bus.gnt, 0);
    rand_ops();

    t = 1; seen = 1'b0;
    while (!seen && t < 400) begin
      tick();
      t++;
      bus.abort = (ab_k >= 0 && t == ab_k + 1);
      if (fz_n > 0) ena = !(t > fz_s && t <= fz_s + fz_n);
      #1;
      if (!ena) begin
        chk("en_frozen", bus.en_rsa, 0);
        chk("clr_frozen", bus.clear_rsa, 0);
      end
      seen = (bus.done != 2'b00);
    end
    bus.abort = 1'b0;
    ena = 1'b1;
    if (!seen) chk("done_seen", 0, 1);
    else begin
      if (st == STAT_OK) res_m = cv;
      chk("gnt_to_done", t, gap);
      chk("done", bus.done, 32'(1) << win);
      chk("status", bus.status, st);
      chk("result", bus.result, res_m);
      chk("clr_in_done", bus.clear_rsa, 1);
      chk("en_in_done", bus.en_rsa, 0);
      chk("rsa_hold", bus.rsa_m, wop[2]);
      last_m = win[0];
    end
  endtask

  task automatic reset_mid();
    tick();
    stub_lat = 0; bus.req = 2'b10; bus.abort = 1'b0;
    #1;
    chk("mid_gnt", bus.gnt, 2'b10);
    repeat (4) tick();
    rstb = 1'b0;
    #1;
    chk("mid_busy", bus.busy, 0);
    chk("mid_en", bus.en_rsa, 0);
    chk("mid_clr", bus.clear_rsa, 0);
    chk("mid_gnt_rst", bus.gnt, 0);
    chk("mid_status", bus.status, 0);
    chk("mid_result", bus.result, 0);
    chk("mid_rsa_e", bus.rsa_e, 0);
    tick();
    chk("mid_done", bus.done, 0);
    bus.req = 2'b00; rstb = 1'b1; last_m = 1'b1; res_m = '0;
    repeat (3) begin
      tick();
      #1;
      chk("mid_no_done", bus.done, 0);
    end
  endtask

  initial begin
    last_m = 1'b1; res_m = '0; stub_lat = 0; stub_c = '0;
    bus.req = 2'b01; bus.abort = 1'b0; rand_ops(); ena = 1'b1;
    #1 rstb = 1'b0;
    #11;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_status", bus.status, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_en", bus.en_rsa, 0);
    chk("rst_clr", bus.clear_rsa, 0);
    chk("rst_rsa_p", bus.rsa_p, 0);
    @(negedge clk);
    rstb = 1'b1; bus.req = 2'b00;

    // ena low in IDLE blocks a grant
    tick();
    ena = 1'b0; bus.req = 2'b01;
    #1;
    chk("frz_idle_gnt", bus.gnt, 0);
    tick();
    #1;
    chk("frz_idle_busy", bus.busy, 0);
    ena = 1'b1; bus.req = 2'b00;

    // both requesting: 0, 1, 0
    for (int j = 0; j < 3; j++) begin
      rand_ops();
      run_job(2'b11, 5, -1, 0, 0, W'($urandom));
    end

    opv[0][0] = 8'd187; opv[0][1] = 8'd7; opv[0][2] = 8'd88; drive_ops();
    run_job(2'b01, 20, -1, 0, 0, 8'h0B);
    run_job(2'b10, 0, -1, 0, 0, 8'h55);
    run_job(2'b01, 7, 7, 0, 0, 8'h66);
    run_job(2'b10, 12, -1, 4, 5, 8'h21);

    for (int j = 0; j < 40; j++) begin
      int         kind, lat, k, s, f;
      logic [1:0] rq;
      rq = 2'($urandom_range(1, 3));
      kind = $urandom_range(0, 3);
      lat = 1; k = -1; s = 0; f = 0;
      case (kind)
        0: lat = $urandom_range(1, 20);
        1: lat = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(TMO + 1, TMO + 10);
        2: begin
          lat = $urandom_range(0, 30);
          k = $urandom_range(0, (lat == 0 || lat > TMO) ? TMO : lat);
        end
        default: begin
          lat = $urandom_range(1, 20);
          s = $urandom_range(1, lat);
          f = $urandom_range(1, 6);
        end
      endcase
      rand_ops();
      repeat ($urandom_range(0, 2)) begin
        tick();
        bus.req = 2'b00;
      end
      run_job(rq, lat, k, s, f, W'($urandom));
    end

    reset_mid();
    rand_ops();
    run_job(2'b11, 3, -1, 0, 0, 8'h3C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
